// File: rtl/erasure_position_source.sv
// Collects GF(2^8) locator values of erased symbols per frame and serves them to the erasure locator.
// Optional ERASURE_POS_PARITY_CHECK_EN: flag frames whose erasure count exceeds no_of_parity.
module erasure_position_source #(
  parameter int         WIDTH        = 5,
  parameter int         MAX_ERASURES = 16,
  parameter int         CODEWORD_LEN = 255,
  parameter logic [7:0] START_LOC    = 8'h8E,
  parameter logic [8:0] PRIM_POLY    = 9'h11D
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic             sym_erase,
  input  logic             sym_last,
  input  logic [WIDTH-1:0] no_of_parity,
  input  logic             send_erasure_positions_for_loc,
  output logic [7:0]       erase_position,
  output logic             erasure_ready,
  output logic             erase_pos_done,
  output logic [WIDTH-1:0] number_of_erasures,
  output logic             erasure_overflow,
  output logic             erasure_uncorrectable,
  output logic             busy
);

  localparam int               IDX_W   = (MAX_ERASURES > 1) ? $clog2(MAX_ERASURES) : 1;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_ERASURES);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // START_LOC already encodes alpha^(CODEWORD_LEN-1); the length itself is not needed in logic.
  localparam int unused_codeword_len = CODEWORD_LEN;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_HOLD, S_SERVE, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_loc, w_loc_cur, w_loc_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_done, w_done_nxt;
  logic [7:0]       r_erase_position, w_pos_nxt;
  logic             r_busy;
  logic             w_accept, w_frame_start, w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [7:0]       r_buf [MAX_ERASURES];

  // Multiply by alpha^-1: undo one left shift of the LFSR, restoring the top bit when the poly was folded in.
  function automatic logic [7:0] step_alpha_inv(input logic [7:0] loc);
    return loc[0] ? (((loc ^ PRIM_POLY[7:0]) >> 1) | 8'h80) : (loc >> 1);
  endfunction

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_loc_cur      = r_loc;
    w_loc_nxt      = r_loc;
    w_count_nxt    = r_count;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_overflow_nxt = r_overflow;
    w_ready_nxt    = 1'b0;
    w_done_nxt     = r_done;
    w_pos_nxt      = r_erase_position;
    w_accept       = 1'b0;
    w_frame_start  = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_idx       = '0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (sym_valid) begin
          w_frame_start  = 1'b1;
          w_accept       = 1'b1;
          w_loc_cur      = START_LOC;
          w_count_nxt    = '0;
          w_rd_ptr_nxt   = '0;
          w_overflow_nxt = 1'b0;
          w_done_nxt     = 1'b0;
        end
      end
      S_COLLECT: w_accept = sym_valid;
      S_HOLD, S_SERVE: begin
        if (r_rd_ptr == r_count) begin
          // Zero erasures still wait for a request; after serving, done follows the last position.
          if (send_erasure_positions_for_loc || r_state == S_SERVE) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (send_erasure_positions_for_loc) begin
          w_pos_nxt    = r_buf[r_rd_ptr[IDX_W-1:0]];
          w_ready_nxt  = 1'b1;
          w_rd_ptr_nxt = r_rd_ptr + ONE;
          w_state_nxt  = S_SERVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept) begin
      w_loc_nxt = step_alpha_inv(w_loc_cur);
      if (sym_erase) begin
        if (w_count_nxt < MAX_CNT) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = w_count_nxt[IDX_W-1:0];
          w_count_nxt = w_count_nxt + ONE;
        end else begin
          w_overflow_nxt = 1'b1;
        end
      end
      w_state_nxt = sym_last ? S_HOLD : S_COLLECT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_loc            <= START_LOC;
      r_count          <= '0;
      r_rd_ptr         <= '0;
      r_overflow       <= 1'b0;
      r_ready          <= 1'b0;
      r_done           <= 1'b0;
      r_erase_position <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_loc            <= w_loc_nxt;
      r_count          <= w_count_nxt;
      r_rd_ptr         <= w_rd_ptr_nxt;
      r_overflow       <= w_overflow_nxt;
      r_ready          <= w_ready_nxt;
      r_done           <= w_done_nxt;
      r_erase_position <= w_pos_nxt;
      r_busy           <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_SERVE);
    end
  end

  // NOTE: the position buffer is not reset; entries are only read below the count, which is reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_buf[w_wr_idx] <= w_loc_cur;
  end

`ifdef ERASURE_POS_PARITY_CHECK_EN
  logic r_uncorrectable;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_uncorrectable <= 1'b0;
    end else if (w_state_nxt == S_HOLD && r_state != S_HOLD) begin
      r_uncorrectable <= w_overflow_nxt || (w_count_nxt > no_of_parity);
    end else if (w_frame_start) begin
      r_uncorrectable <= 1'b0;
    end
  end
  assign erasure_uncorrectable = r_uncorrectable;
`else
  logic w_unused_parity;
  assign w_unused_parity       = ^no_of_parity;
  assign erasure_uncorrectable = 1'b0;
`endif

  assign erase_position     = r_erase_position;
  assign erasure_ready      = r_ready;
  assign erase_pos_done     = r_done;
  assign number_of_erasures = r_count;
  assign erasure_overflow   = r_overflow;
  assign busy               = r_busy;

endmodule

// File: tb/tb_erasure_position_source.sv
// Randomized self-checking bench for erasure_position_source; expected positions come from
// alpha powers computed by repeated GF(2^8) doubling, independent of the RTL's alpha^-1 stepping.
module tb_erasure_position_source;

  localparam int WIDTH = 5;
  localparam int MAXE  = 16;
  localparam int N     = 255;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             sym_valid = 1'b0;
  logic             sym_erase = 1'b0;
  logic             sym_last = 1'b0;
  logic [WIDTH-1:0] no_of_parity = '1;
  logic             send = 1'b0;
  logic [7:0]       erase_position;
  logic             erasure_ready;
  logic             erase_pos_done;
  logic [WIDTH-1:0] number_of_erasures;
  logic             erasure_overflow;
  logic             erasure_uncorrectable;
  logic             busy;

  erasure_position_source dut (
    .clock                          (clock),
    .reset                          (reset),
    .sym_valid                      (sym_valid),
    .sym_erase                      (sym_erase),
    .sym_last                       (sym_last),
    .no_of_parity                   (no_of_parity),
    .send_erasure_positions_for_loc (send),
    .erase_position                 (erase_position),
    .erasure_ready                  (erasure_ready),
    .erase_pos_done                 (erase_pos_done),
    .number_of_erasures             (number_of_erasures),
    .erasure_overflow               (erasure_overflow),
    .erasure_uncorrectable          (erasure_uncorrectable),
    .busy                           (busy)
  );

  always #5 clock = ~clock;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  erase_map [N];
  int  exp_q [$];
  int  exp_count;
  bit  exp_ovf;
  bit  exp_unc;

  // alpha^e by repeated multiplication by x modulo x^8+x^4+x^3+x^2+1.
  function automatic int gf_alpha_pow(input int e);
    int v = 1;
    for (int i = 0; i < e; i++) begin
      v = v << 1;
      if ((v & 'h100) != 0) v = v ^ 'h11D;
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_map;
    for (int k = 0; k < N; k++) erase_map[k] = 1'b0;
  endtask

  task automatic set_random_erasures(input int count, input int len);
    int placed = 0;
    clear_map();
    while (placed < count) begin
      int k = $urandom_range(0, len - 1);
      if (!erase_map[k]) begin
        erase_map[k] = 1'b1;
        placed++;
      end
    end
  endtask

  task automatic drive_frame(input int len, input int parity);
    int running = 0;
    bit ovf = 1'b0;
    exp_q.delete();
    no_of_parity = WIDTH'(parity);
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        sym_valid = 1'b0;
        sym_erase = 1'($urandom_range(0, 1));
        sym_last  = 1'b0;
        tick();
      end
      sym_valid = 1'b1;
      sym_erase = erase_map[k];
      sym_last  = (k == len - 1);
      tick();
      if (erase_map[k]) begin
        if (running < MAXE) begin
          running++;
          exp_q.push_back(gf_alpha_pow(N - 1 - k));
        end else begin
          ovf = 1'b1;
        end
      end
      n_tests++;
      if (number_of_erasures !== WIDTH'(running)) begin
        n_fail++;
        $display("FAIL count_k%0d: got %0d expected %0d", k, number_of_erasures, running);
      end
    end
    sym_valid = 1'b0;
    sym_erase = 1'b0;
    sym_last  = 1'b0;
    exp_count = running;
    exp_ovf   = ovf;
`ifdef ERASURE_POS_PARITY_CHECK_EN
    exp_unc = ovf || (running > parity);
`else
    exp_unc = 1'b0;
`endif
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy: got %b expected 1", busy);
    end
    n_tests++;
    if (erasure_overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b expected %b", erasure_overflow, exp_ovf);
    end
    n_tests++;
    if (erasure_uncorrectable !== exp_unc) begin
      n_fail++;
      $display("FAIL uncorrectable: got %b expected %b", erasure_uncorrectable, exp_unc);
    end
  endtask

  // Idle in HOLD while upstream ignores busy: nothing may change.
  task automatic hold_and_poke(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      sym_valid = 1'b1;
      sym_erase = 1'b1;
      sym_last  = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (number_of_erasures !== WIDTH'(exp_count) || busy !== 1'b1 ||
          erasure_ready !== 1'b0 || erase_pos_done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cnt=%0d busy=%b rdy=%b done=%b expected cnt=%0d busy=1 rdy=0 done=0",
                 number_of_erasures, busy, erasure_ready, erase_pos_done, exp_count);
      end
    end
    sym_valid = 1'b0;
    sym_erase = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic serve(input int pause_after, input int pause_len);
    int n = exp_q.size();
    send = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == pause_after) begin
        send = 1'b0;
        for (int j = 0; j < pause_len; j++) begin
          tick();
          n_tests++;
          if (erasure_ready !== 1'b0 || erase_pos_done !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_gap%0d: rdy=%b done=%b expected 0 0", j, erasure_ready, erase_pos_done);
          end
        end
        send = 1'b1;
      end
      tick();
      n_tests++;
      if (erasure_ready !== 1'b1 || erase_position !== 8'(exp_q[i]) || erase_pos_done !== 1'b0) begin
        n_fail++;
        $display("FAIL serve_pos%0d: rdy=%b pos=%02h done=%b expected rdy=1 pos=%02h done=0",
                 i, erasure_ready, erase_position, erase_pos_done, exp_q[i]);
      end
    end
    tick();
    n_tests++;
    if (erase_pos_done !== 1'b1 || erasure_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL serve_done: done=%b rdy=%b expected done=1 rdy=0", erase_pos_done, erasure_ready);
    end
    send = 1'b0;
    tick();
    n_tests++;
    if (erase_pos_done !== 1'b1 || busy !== 1'b0 || number_of_erasures !== WIDTH'(exp_count) ||
        erasure_overflow !== exp_ovf || erasure_uncorrectable !== exp_unc) begin
      n_fail++;
      $display("FAIL done_held: done=%b busy=%b cnt=%0d ovf=%b unc=%b expected 1 0 %0d %b %b",
               erase_pos_done, busy, number_of_erasures, erasure_overflow, erasure_uncorrectable,
               exp_count, exp_ovf, exp_unc);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (erase_position !== 8'h00 || erasure_ready !== 1'b0 || erase_pos_done !== 1'b0 ||
        number_of_erasures !== '0 || erasure_overflow !== 1'b0 ||
        erasure_uncorrectable !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pos=%02h rdy=%b done=%b cnt=%0d ovf=%b unc=%b busy=%b expected all 0", name,
               erase_position, erasure_ready, erase_pos_done, number_of_erasures,
               erasure_overflow, erasure_uncorrectable, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset_state");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_ends;
    clear_map();
    erase_map[0]   = 1'b1;
    erase_map[N-1] = 1'b1;
    drive_frame(N, 31);
    hold_and_poke(2);
    serve(-1, 0);
  endtask

  task automatic test_no_erasures;
    clear_map();
    drive_frame(N, 31);
    serve(-1, 0);
  endtask

  task automatic test_overflow;
    set_random_erasures(18, N);
    drive_frame(N, 31);
    serve(-1, 0);
  endtask

  task automatic test_overflow_on_last;
    // 17th erasure lands on the last symbol.
    clear_map();
    for (int k = 0; k < 17; k++) erase_map[k * 15] = 1'b1;
    drive_frame(241, 31);
    serve(-1, 0);
  endtask

  task automatic test_pause;
    set_random_erasures(5, N);
    drive_frame(N, 31);
    serve(2, 3);
  endtask

  task automatic test_reset_mid;
    set_random_erasures(5, N);
    drive_frame(N, 31);
    send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (erasure_ready !== 1'b1 || erase_position !== 8'(exp_q[i])) begin
        n_fail++;
        $display("FAIL pre_reset_pos%0d: rdy=%b pos=%02h expected 1 %02h",
                 i, erasure_ready, erase_position, exp_q[i]);
      end
    end
    reset = 1'b1;
    send  = 1'b0;
    tick();
    check_all_zero("reset_mid");
    reset = 1'b0;
    clear_map();
    erase_map[1] = 1'b1;
    drive_frame(N, 31);
    send = 1'b1;
    tick();
    n_tests++;
    if (erasure_ready !== 1'b1 || erase_position !== 8'h47) begin
      n_fail++;
      $display("FAIL post_reset_k1: rdy=%b pos=%02h expected 1 47", erasure_ready, erase_position);
    end
    tick();
    n_tests++;
    if (erase_pos_done !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_done: got %b expected 1", erase_pos_done);
    end
    send = 1'b0;
    tick();
  endtask

  task automatic test_parity;
    set_random_erasures(5, N);
    drive_frame(N, 4);
    serve(-1, 0);
    set_random_erasures(4, N);
    drive_frame(N, 4);
    serve(-1, 0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 8; f++) begin
      int len = (f == 0) ? 1 : $urandom_range(2, N);
      int ne  = $urandom_range(0, (len < 20) ? len : 20);
      set_random_erasures(ne, len);
      drive_frame(len, $urandom_range(0, 31));
      serve((ne > 1) ? $urandom_range(0, ne - 1) : -1, $urandom_range(1, 4));
    end
  endtask

  initial begin
    test_reset();
    test_frame_ends();
    test_no_erasures();
    test_overflow();
    test_overflow_on_last();
    test_pause();
    test_reset_mid();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/erasure_position_source.md
# erasure_position_source

Produces the erasure positions consumed by the erasure locator polynomial generator. It watches the incoming received-symbol stream, which carries a per-symbol erasure flag. For each erased symbol it stores the GF(2^8) locator value alpha^(CODEWORD_LEN-1-k), where k is the symbol's index in the frame. When the locator requests positions, it serves the stored values one per cycle, with a ready strobe and a done flag. It sits between the symbol front end and the locator stage of the Reed-Solomon decoder.

## Interface
- WIDTH, 5: width of the erasure count and parity count.
- MAX_ERASURES, 16: depth of the position buffer.
- CODEWORD_LEN, 255: symbols per frame.
- START_LOC, 8'h8E: alpha^(CODEWORD_LEN-1), the locator value of symbol 0.
- PRIM_POLY, 9'h11D: field generator polynomial.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- sym_valid  in  1  a symbol is present this cycle.
- sym_erase  in  1  erasure flag of the current symbol.
- sym_last  in  1  the current symbol is the last of the frame.
- no_of_parity  in  WIDTH  number of parity symbols (2t).
- send_erasure_positions_for_loc  in  1  level request from the locator.
- erase_position  out  8  locator value being served.
- erasure_ready  out  1  erase_position is valid this cycle.
- erase_pos_done  out  1  all stored positions have been served.
- number_of_erasures  out  WIDTH  erasures stored for the current frame.
- erasure_overflow  out  1  the frame had more than MAX_ERASURES erasures.
- erasure_uncorrectable  out  1  number_of_erasures > no_of_parity (macro-dependent).
- busy  out  1  the block is in the HOLD or SERVE state.

## Operation
- FSM states: IDLE, COLLECT, HOLD, SERVE, DONE.
- IDLE/DONE to COLLECT: on sym_valid. Entering COLLECT from DONE first clears the count, the pointers and all flags. The first symbol is processed in that same cycle.
- Locator register loc:
  - Loaded with START_LOC when a frame starts.
  - After each accepted symbol, stepped by alpha^-1: loc = loc[0] ? ((loc ^ PRIM_POLY[7:0]) >> 1) | 8'h80 : loc >> 1.
- Accepting an erased symbol (sym_valid=1, sym_erase=1):
  - If count < MAX_ERASURES: write loc to buf[count] and increment count.
  - Otherwise: set erasure_overflow; the count saturates and the position is discarded.
- COLLECT to HOLD: on an accepted symbol with sym_last=1.
- HOLD: number_of_erasures is stable. Go to SERVE when the request is high.
- SERVE, request high:
  - If rd_ptr < count: drive erase_position=buf[rd_ptr], erasure_ready=1, then rd_ptr++.
  - When rd_ptr reaches count, set erase_pos_done=1 and go to DONE.
- SERVE, request low: pause. erasure_ready=0 and rd_ptr is held.
- Zero erasures: on the first request cycle in SERVE, erase_pos_done=1 and no erasure_ready pulse is issued.
- sym_valid in HOLD or SERVE is ignored. The upstream block must honour busy.
- DONE: erase_pos_done, number_of_erasures and the flags are held until the next frame starts.

## Timing
- Reset values: erase_position=0, erasure_ready=0, erase_pos_done=0, number_of_erasures=0, erasure_overflow=0, erasure_uncorrectable=0, busy=0. State goes to IDLE and loc to START_LOC.
- All outputs are registered.
- Symbol accepted at edge t: the count update is visible at t+1.
- sym_last accepted at edge t: state=HOLD and busy=1 at t+1.
- Request sampled high at edge t: first erasure_ready/erase_position at t+1, then one position per cycle while the request stays high.
- erase_pos_done asserts in the cycle after the last erasure_ready. With zero erasures it asserts one cycle after the request.
- Reset mid-operation: abort at once. The buffer contents are don't-care; count and pointers return to 0.
- sym_last together with the erasure that makes count exceed MAX_ERASURES: set overflow and still go to HOLD.

## Configuration
- ERASURE_POS_PARITY_CHECK_EN defined:
  - erasure_uncorrectable is registered in the cycle of entering HOLD as (number_of_erasures > no_of_parity), or forced to 1 when erasure_overflow=1.
  - The flag is held through DONE.
- Undefined: erasure_uncorrectable is tied to 0 and no_of_parity is unused.

## Test plan
- Frame of 255 symbols, erasures at k=0 and k=254, request held high:
  - erasure_ready pulses twice with erase_position 8'h8E then 8'h01.
  - number_of_erasures=2; erase_pos_done on the following cycle.
- Frame with no erasures, request high: no erasure_ready pulse; erase_pos_done=1 one cycle after the request; count=0.
- 18 erasures with MAX_ERASURES=16:
  - erasure_overflow=1, number_of_erasures=16, 16 positions served.
  - With the macro defined, erasure_uncorrectable=1.
- Request dropped after 2 of 5 positions for 3 cycles:
  - erasure_ready stays low during the gap.
  - Serving resumes with the 3rd position; the sequence has no gaps or repeats.
- Reset asserted at the 3rd served position: all outputs return to 0. A following frame with one erasure at k=1 serves 8'h47.
- Macro defined, no_of_parity=4, 5 erasures: erasure_uncorrectable=1 on entry to HOLD. With 4 erasures it stays 0.
